stream_arbiter: RTL

- Round-robin arbiter that shares one AXI4-Stream-style datapath (valid/ready/data) among NUM_PORTS requesters.
- Grants one requester for a burst of up to cfg_burst beats, then rotates priority.
- Output is registered and drives downstream stream buffers directly.
- out_port tags each beat with its source index.

---
 rtl/stream_arbiter_pkg.sv | 9 +
 rtl/stream_arbiter_rr_picker.sv | 33 +++
 rtl/stream_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/stream_arbiter_pkg.sv
// rtl/stream_arbiter_pkg.sv - shared state encoding for the round-robin stream arbiter
package stream_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/stream_arbiter_rr_picker.sv
// rtl/stream_arbiter_rr_picker.sv - rotating-priority search starting at ptr, wrapping modulo NUM_PORTS
module stream_arbiter_rr_picker #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0]  req,
    input  logic [PORT_WIDTH-1:0] ptr,
    output logic                  found,
    output logic [PORT_WIDTH-1:0] idx
);

    // Requests laid out twice so a window starting at ptr never needs a wrap test.
    logic [2*NUM_PORTS-2:0] dbl;

    assign dbl = {req[NUM_PORTS-2:0], req};

    // Scanning downward lets the lowest offset from ptr win.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (dbl[int'(ptr) + k]) begin
                found = 1'b1;
                if (int'(ptr) + k >= NUM_PORTS) begin
                    idx = PORT_WIDTH'(int'(ptr) + k - NUM_PORTS);
                end else begin
                    idx = PORT_WIDTH'(int'(ptr) + k);
                end
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// rtl/stream_arbiter.sv - round-robin burst arbiter sharing one registered valid/ready stream
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_PORTS   = 4,
    parameter int PORT_WIDTH  = 2,
    parameter int BURST_WIDTH = 8
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [BURST_WIDTH-1:0]          cfg_burst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PORT_WIDTH-1:0]           out_port,
    output logic [NUM_PORTS-1:0]            sts_grant
);

    state_t                  state;
    state_t                  next_state;
    logic [PORT_WIDTH-1:0]   ptr;
    logic [PORT_WIDTH-1:0]   grant_idx;
    logic [BURST_WIDTH-1:0]  burst;
    logic [BURST_WIDTH-1:0]  count;
    logic                    found;
    logic [PORT_WIDTH-1:0]   pick_idx;
    logic                    sel_valid;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [NUM_PORTS-1:0]    grant_onehot;
    logic                    accept;
    logic                    xfer;
    logic                    release_grant;

    stream_arbiter_rr_picker #(
        .NUM_PORTS  (NUM_PORTS),
        .PORT_WIDTH (PORT_WIDTH)
    ) u_rr_picker (
        .req   (in_valid),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_valid    = 1'b0;
        sel_data     = '0;
        grant_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == PORT_WIDTH'(i)) begin
                sel_valid       = in_valid[i];
                sel_data        = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                grant_onehot[i] = 1'b1;
            end
        end
    end

    // The output register can take a new beat when empty or draining this cycle.
    assign accept        = !out_valid || out_ready;
    assign in_ready      = (state == GRANT && accept) ? grant_onehot : '0;
    assign sts_grant     = (state == GRANT) ? grant_onehot : '0;
    assign xfer          = (state == GRANT) && sel_valid && accept;
    assign release_grant = (state == GRANT) &&
                           (!sel_valid || (xfer && count == burst - BURST_WIDTH'(1)));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = GRANT;
            GRANT:   if (release_grant) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            burst     <= '0;
            count     <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && found) begin
                grant_idx <= pick_idx;
                burst     <= (cfg_burst == '0) ? BURST_WIDTH'(1) : cfg_burst;
                count     <= '0;
            end
            if (xfer) begin
                count <= count + BURST_WIDTH'(1);
            end
            if (release_grant) begin
                ptr <= (grant_idx == PORT_WIDTH'(NUM_PORTS - 1)) ? '0
                                                                 : grant_idx + PORT_WIDTH'(1);
            end
        end
    end

    // Output register drains on its own, so a beat pending at release still completes.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_port  <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
